// File: rtl/xor_frame_cipher_pkg.sv
// Shared definitions for the framed repeating-key XOR cipher: mode bit
// positions and FSM state encoding used by the RTL and the bench alike.
package xor_frame_cipher_pkg;

    localparam int MODE_CHAIN = 0;
    localparam int MODE_DEC   = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_KLEN = 3'd1,
        ST_GET_KEY  = 3'd2,
        ST_SEND_LEN = 3'd3,
        ST_RUN      = 3'd4,
        ST_DRAIN    = 3'd5
    } state_t;

endpackage

// File: rtl/xor_frame_cipher_frame_buffer.sv
// Result buffer for the cipher: single-clock RAM, synchronous write port,
// asynchronous read port. Contents are intentionally not reset.
module frame_buffer
    import xor_frame_cipher_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 100,
    parameter int AW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xor_frame_cipher.sv
// Framed repeating-key XOR cipher (plain/chained, encrypt/decrypt) between
// the UART receiver and sender, with a readable copy of the last result frame.
module xor_frame_cipher
    import xor_frame_cipher_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 100,
    parameter int MAX_KEY = 4,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  frame_len,
    input  logic [LEN_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    // state       | meaning
    // IDLE        | wait for LEN byte, reject 0 or > MAX_LEN
    // GET_KLEN    | wait for key length, reject 0 or > MAX_KEY
    // GET_KEY     | collect KLEN key bytes
    // SEND_LEN    | present LEN as the first response byte
    // RUN         | cipher LEN data bytes, one per accept
    // DRAIN       | wait for the last response byte to leave, pulse done

    localparam int KW   = $clog2(MAX_KEY + 1);
    localparam int KI_W = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;

    state_t state, state_nx;

    logic [LEN_W-1:0]  len, didx;
    logic [KW-1:0]     klen, kidx;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] key [MAX_KEY];
    logic [DATA_W-1:0] prev, k, y, buf_rd;
    logic              in_acc, out_acc, len_bad, klen_bad, key_last, data_last;
    logic              buf_we;

    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign len_bad   = (in_data == '0) || (in_data > DATA_W'(MAX_LEN));
    assign klen_bad  = (in_data == '0) || (in_data > DATA_W'(MAX_KEY));
    assign key_last  = (kidx + KW'(1)) == klen;
    assign data_last = (didx + LEN_W'(1)) == len;
    assign k         = key[kidx[KI_W-1:0]];
    assign y         = in_data ^ k ^ (mode_q[MODE_CHAIN] ? prev : '0);
    assign buf_we    = (state == ST_RUN) && in_acc;

    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (in_acc && !len_bad) state_nx = ST_GET_KLEN;
            ST_GET_KLEN: if (in_acc) state_nx = klen_bad ? ST_IDLE : ST_GET_KEY;
            ST_GET_KEY:  if (in_acc && key_last) state_nx = ST_SEND_LEN;
            ST_SEND_LEN: if (out_acc) state_nx = ST_RUN;
            ST_RUN:      if (in_acc && data_last) state_nx = ST_DRAIN;
            ST_DRAIN:    if (out_acc) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // in_ready is held low for as long as Reset is asserted
    always_comb begin
        busy     = (state != ST_IDLE);
        in_ready = 1'b0;
        case (state)
            ST_IDLE, ST_GET_KLEN, ST_GET_KEY: in_ready = Reset;
            ST_RUN:                           in_ready = !out_valid || out_ready;
            default:                          in_ready = 1'b0;
        endcase
    end

    // frame_len commits only once the key is complete, so a rejected KLEN
    // leaves the previous frame fully readable
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            frame_len <= '0;
            len       <= '0;
            didx      <= '0;
            klen      <= '0;
            kidx      <= '0;
            mode_q    <= '0;
            prev      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_acc) begin
                        if (len_bad) begin
                            error <= 1'b1;
                        end else begin
                            error  <= 1'b0;
                            len    <= LEN_W'(in_data);
                            mode_q <= mode;
                            didx   <= '0;
                            prev   <= '0;
                        end
                    end
                end
                ST_GET_KLEN: begin
                    if (in_acc) begin
                        if (klen_bad) begin
                            error <= 1'b1;
                        end else begin
                            klen <= KW'(in_data);
                            kidx <= '0;
                        end
                    end
                end
                ST_GET_KEY: begin
                    if (in_acc) begin
                        if (key_last) begin
                            kidx      <= '0;
                            out_data  <= DATA_W'(len);
                            out_valid <= 1'b1;
                            frame_len <= len;
                        end else begin
                            kidx <= kidx + KW'(1);
                        end
                    end
                end
                ST_SEND_LEN: begin
                    if (out_acc) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (in_acc) begin
                        out_data  <= y;
                        out_valid <= 1'b1;
                        didx      <= didx + LEN_W'(1);
                        kidx      <= key_last ? '0 : kidx + KW'(1);
                        if (mode_q[MODE_CHAIN]) begin
                            prev <= mode_q[MODE_DEC] ? in_data : y;
                        end
                    end else if (out_acc) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (out_acc) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_100M) begin
        if ((state == ST_GET_KEY) && in_acc) begin
            key[kidx[KI_W-1:0]] <= in_data;
        end
    end

    frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_LEN),
        .AW     (LEN_W)
    ) u_frame_buffer (
        .clk     (Clk_100M),
        .we      (buf_we),
        .wr_addr (didx),
        .wr_data (y),
        .rd_addr (rd_idx),
        .rd_data (buf_rd)
    );

    assign rd_data = (rd_idx < frame_len) ? buf_rd : '0;

endmodule
